// File: rtl/ddr_in_deser_if.sv
// Word-side handshake of the DDR deserialiser: assembled word with valid/ready.
interface ddr_in_deser_if #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
);
  logic [2*RATIO*WIDTH-1:0] word_out;
  logic                     word_valid;
  logic                     word_ready;

  modport master (output word_out, output word_valid, input word_ready);
  modport slave  (input word_out, input word_valid, output word_ready);
endinterface

// File: rtl/ddr_in_deser.sv
// DDR input capture on both clock edges, posedge realignment and RATIO-pair word assembly
// with a valid/ready output and sticky overflow on dropped words.
module ddr_in_deser #(
  parameter int WIDTH     = 8,
  parameter int RATIO     = 4,
  parameter int SAME_EDGE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  input  logic             ce,
  input  logic             r,
  input  logic             s,
  input  logic             slip,
  output logic [WIDTH-1:0] q_rise,
  output logic [WIDTH-1:0] q_fall,
  output logic             overflow,
  input  logic             ovf_clr,
  ddr_in_deser_if.master   wd
);

  localparam int WORD_W = 2 * RATIO * WIDTH;
  localparam int CNT_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  logic [WIDTH-1:0]   rise_reg;
  logic [WIDTH-1:0]   fall_reg;
  logic               primed_reg;
  logic [2*WIDTH-1:0] pair_next;
  logic [2*WIDTH-1:0] slot_reg [RATIO];
  logic [CNT_W-1:0]   cnt_reg;
  logic [WORD_W-1:0]  word_next;
  logic [WORD_W-1:0]  word_reg;
  logic               valid_reg;
  logic               overflow_reg;
  logic               accept_next;
  logic               take_next;
  logic               complete_next;

  // primed_reg marks that rise_reg holds a real sample, so a fresh start never packs the reset zeros.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_reg   <= '0;
      primed_reg <= 1'b0;
    end else if (r) begin
      rise_reg   <= '0;
      primed_reg <= 1'b0;
    end else if (s) begin
      rise_reg   <= '1;
      primed_reg <= 1'b1;
    end else if (ce) begin
      rise_reg   <= d;
      primed_reg <= 1'b1;
    end
  end

  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fall_reg <= '0;
    end else if (r) begin
      fall_reg <= '0;
    end else if (s) begin
      fall_reg <= '1;
    end else if (ce) begin
      fall_reg <= d;
    end
  end

  generate
    if (SAME_EDGE != 0) begin : g_same_edge
      logic [WIDTH-1:0] rise_align_reg;
      logic [WIDTH-1:0] fall_align_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rise_align_reg <= '0;
          fall_align_reg <= '0;
        end else if (r) begin
          rise_align_reg <= '0;
          fall_align_reg <= '0;
        end else begin
          rise_align_reg <= rise_reg;
          fall_align_reg <= fall_reg;
        end
      end

      assign q_rise = rise_align_reg;
      assign q_fall = fall_align_reg;
    end else begin : g_split_edge
      assign q_rise = rise_reg;
      assign q_fall = fall_reg;
    end
  endgenerate

  // At a posedge, rise_reg holds the previous posedge sample and fall_reg the negedge after it.
  assign pair_next     = {fall_reg, rise_reg};
  assign accept_next   = ce & ~r & primed_reg;
  assign take_next     = accept_next & ~slip;
  assign complete_next = take_next & (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < RATIO; k++) begin
        slot_reg[k] <= '0;
      end
      cnt_reg <= '0;
    end else if (r) begin
      for (int k = 0; k < RATIO; k++) begin
        slot_reg[k] <= '0;
      end
      cnt_reg <= '0;
    end else if (take_next) begin
      slot_reg[cnt_reg] <= pair_next;
      cnt_reg           <= complete_next ? '0 : cnt_reg + CNT_W'(1);
    end
  end

  // The completing pair bypasses its slot so the word is ready at the same posedge.
  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_pack
      assign word_next[2*gi*WIDTH +: 2*WIDTH] =
        (cnt_reg == CNT_W'(gi)) ? pair_next : slot_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_reg     <= '0;
      valid_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (complete_next && (!valid_reg || wd.word_ready)) begin
        word_reg  <= word_next;
        valid_reg <= 1'b1;
      end else if (valid_reg && wd.word_ready) begin
        valid_reg <= 1'b0;
      end
      // A new drop outranks a simultaneous clear.
      if (complete_next && valid_reg && !wd.word_ready) begin
        overflow_reg <= 1'b1;
      end else if (ovf_clr) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  assign wd.word_out   = word_reg;
  assign wd.word_valid = valid_reg;
  assign overflow      = overflow_reg;

endmodule
